// File: rtl/y_operand_stage_if.sv
// Handshake and operand bundle between the ID stage, the Y-operand stage and EX.
// master = upstream/downstream environment side, slave = the operand stage itself.
interface y_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] b;
  logic [2:0]        y_sel;
  logic [TAG_W-1:0]  tag_in;
  logic [1:0]        fwd_sel;
  logic [DATA_W-1:0] fwd_exmem;
  logic [DATA_W-1:0] fwd_memwb;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y;
  logic [TAG_W-1:0]  tag_out;
  logic [1:0]        occupancy;

  modport master (
    output flush,
    output in_valid,
    output instr,
    output b,
    output y_sel,
    output tag_in,
    output fwd_sel,
    output fwd_exmem,
    output fwd_memwb,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  tag_out,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  instr,
    input  b,
    input  y_sel,
    input  tag_in,
    input  fwd_sel,
    input  fwd_exmem,
    input  fwd_memwb,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output tag_out,
    output occupancy
  );

endinterface

// File: rtl/y_operand_stage.sv
// EX-stage second ALU operand select behind a 2-entry skid buffer (output reg + skid reg).
// Define Y_OPERAND_FWD_EN to enable EX/MEM and MEM/WB forwarding into the B operand.
module y_operand_stage #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int SHAMT_W   = 5,
  parameter int SHAMT_LSB = 6,
  parameter int TAG_W     = 8
) (
  input logic              clk,
  input logic              rst_n,
  y_operand_stage_if.slave bus
);

  generate
    if (DATA_W < 2 * IMM_W) begin : g_bad_data_w
      $error("y_operand_stage: DATA_W (%0d) must be >= 2*IMM_W (%0d)", DATA_W, 2 * IMM_W);
    end
    if (SHAMT_LSB + SHAMT_W > DATA_W) begin : g_bad_shamt
      $error("y_operand_stage: shamt field exceeds instruction width");
    end
  endgenerate

  localparam logic [2:0] SEL_B     = 3'd0;
  localparam logic [2:0] SEL_SHAMT = 3'd1;
  localparam logic [2:0] SEL_ZERO  = 3'd2;
  localparam logic [2:0] SEL_SEXT  = 3'd3;
  localparam logic [2:0] SEL_ZEXT  = 3'd4;
  localparam logic [2:0] SEL_UPPER = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] or_data;
  logic [TAG_W-1:0]  or_tag;
  logic [DATA_W-1:0] sk_data;
  logic [TAG_W-1:0]  sk_tag;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [1:0]        occupancy_q;

  logic [IMM_W-1:0]   imm;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  bsrc;
  logic [DATA_W-1:0]  operand;
  logic               accept;
  logic               transfer;

  assign imm   = bus.instr[IMM_W-1:0];
  assign shamt = bus.instr[SHAMT_LSB +: SHAMT_W];

`ifdef Y_OPERAND_FWD_EN
  always_comb begin
    bsrc = bus.b;
    case (bus.fwd_sel)
      2'd1:    bsrc = bus.fwd_exmem;
      2'd2:    bsrc = bus.fwd_memwb;
      default: bsrc = bus.b;
    endcase
  end

  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr;
`else
  assign bsrc = bus.b;

  // Forwarding inputs stay on the interface but feed nothing in this build.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr, bus.fwd_sel, bus.fwd_exmem, bus.fwd_memwb};
`endif

  always_comb begin
    operand = '0;
    case (bus.y_sel)
      SEL_B:     operand = bsrc;
      SEL_SHAMT: operand = DATA_W'(shamt);
      SEL_ZERO:  operand = '0;
      SEL_SEXT:  operand = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
      SEL_ZEXT:  operand = DATA_W'(imm);
      SEL_UPPER: operand = DATA_W'(imm) << IMM_W;
      default:   operand = '0;
    endcase
  end

  assign accept   = bus.in_valid && in_ready_q;
  assign transfer = out_valid_q && bus.out_ready;

  // in_ready is registered so a downstream stall never reaches ID combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      or_data     <= '0;
      or_tag      <= '0;
      sk_data     <= '0;
      sk_tag      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else if (bus.flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            or_data     <= operand;
            or_tag      <= bus.tag_in;
            out_valid_q <= 1'b1;
            occupancy_q <= 2'd1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            or_data <= operand;
            or_tag  <= bus.tag_in;
          end else if (transfer) begin
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
            state       <= EMPTY;
          end else if (accept) begin
            sk_data     <= operand;
            sk_tag      <= bus.tag_in;
            in_ready_q  <= 1'b0;
            occupancy_q <= 2'd2;
            state       <= FULL;
          end
        end
        FULL: begin
          if (transfer) begin
            or_data     <= sk_data;
            or_tag      <= sk_tag;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd1;
            state       <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occupancy_q <= 2'd0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.y         = or_data;
  assign bus.tag_out   = or_tag;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.occupancy = occupancy_q;

endmodule

// File: tb/tb_y_operand_stage.sv
// Directed self-checking bench for y_operand_stage; expectations follow Y_OPERAND_FWD_EN.
module tb_y_operand_stage;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  y_operand_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  y_operand_stage #(
    .DATA_W(DATA_W),
    .IMM_W(16),
    .SHAMT_W(5),
    .SHAMT_LSB(6),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic [31:0] instr,
                               input logic [31:0] b, input logic [7:0] tag);
    bus.in_valid = valid;
    bus.y_sel    = sel;
    bus.instr    = instr;
    bus.b        = b;
    bus.tag_in   = tag;
  endtask

  logic [2:0]  sels   [9] = '{3'd3, 3'd4, 3'd5, 3'd3, 3'd1, 3'd0, 3'd6, 3'd2, 3'd7};
  logic [31:0] instrs [9] = '{32'h0000_FFFE, 32'h0000_FFFE, 32'h0000_FFFE, 32'h0000_7FFF,
                              32'hFFFF_FC7F, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF};
  logic [31:0] bs     [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] exps   [9] = '{32'hFFFF_FFFE, 32'h0000_FFFE, 32'hFFFE_0000, 32'h0000_7FFF,
                              32'd17, 32'h1234_5678, 32'h0, 32'h0, 32'h0};

`ifdef Y_OPERAND_FWD_EN
  localparam logic [31:0] EXP_FWD1 = 32'h0000_00AA;
  localparam logic [31:0] EXP_FWD2 = 32'h0000_00BB;
`else
  localparam logic [31:0] EXP_FWD1 = 32'h0000_0001;
  localparam logic [31:0] EXP_FWD2 = 32'h0000_0001;
`endif

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.fwd_sel   = 2'd0;
    bus.fwd_exmem = '0;
    bus.fwd_memwb = '0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_y", bus.y, 32'h0);
    checkOutput("rst_tag_out", 32'(bus.tag_out), 32'd0);
    rst_n = 1'b1;

    // Operand modes back to back at full throughput
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, sels[i], instrs[i], bs[i], 8'(16 + i));
      @(negedge clk);
      checkOutput($sformatf("mode%0d_valid", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("mode%0d_y_sel%0d", i, sels[i]), bus.y, exps[i]);
      checkOutput($sformatf("mode%0d_tag", i), 32'(bus.tag_out), 32'(16 + i));
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    @(negedge clk);
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_occupancy", 32'(bus.occupancy), 32'd0);

    // Back-pressure fills both entries, then drains in order with no bubble
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h111, 8'd1);
    @(negedge clk);
    checkOutput("bp_occ1", 32'(bus.occupancy), 32'd1);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h222, 8'd2);
    @(negedge clk);
    checkOutput("bp_occ2", 32'(bus.occupancy), 32'd2);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_y_tag1", bus.y, 32'h111);
    checkOutput("bp_tag1", 32'(bus.tag_out), 32'd1);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h333, 8'd3);
    @(negedge clk);
    checkOutput("bp_hold_y", bus.y, 32'h111);
    checkOutput("bp_hold_tag", 32'(bus.tag_out), 32'd1);
    checkOutput("bp_hold_occ", 32'(bus.occupancy), 32'd2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_tag2", 32'(bus.tag_out), 32'd2);
    checkOutput("bp_y_tag2", bus.y, 32'h222);
    checkOutput("bp_occ_after", 32'(bus.occupancy), 32'd1);
    checkOutput("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    checkOutput("bp_tag3_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_tag3", 32'(bus.tag_out), 32'd3);
    checkOutput("bp_y_tag3", bus.y, 32'h333);
    @(negedge clk);
    checkOutput("bp_empty", 32'(bus.out_valid), 32'd0);

    // Flush while full, with a beat offered in the flush cycle
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h444, 8'd4);
    @(negedge clk);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h555, 8'd5);
    @(negedge clk);
    checkOutput("fl_occ_full", 32'(bus.occupancy), 32'd2);
    bus.flush = 1'b1;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h999, 8'd9);
    @(negedge clk);
    checkOutput("fl_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("fl_in_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    repeat (3) @(negedge clk);
    checkOutput("fl_no_tag9", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_occ_stays0", 32'(bus.occupancy), 32'd0);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'hA0A, 8'd10);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    checkOutput("fl_post_y", bus.y, 32'hA0A);
    checkOutput("fl_post_tag", 32'(bus.tag_out), 32'd10);
    @(negedge clk);

    // Forwarding into the B operand
    bus.fwd_exmem = 32'hAA;
    bus.fwd_memwb = 32'hBB;
    bus.fwd_sel   = 2'd1;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h1, 8'h20);
    @(negedge clk);
    checkOutput("fwd_exmem", bus.y, EXP_FWD1);
    bus.fwd_sel = 2'd2;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h1, 8'h21);
    @(negedge clk);
    checkOutput("fwd_memwb", bus.y, EXP_FWD2);
    bus.fwd_sel = 2'd3;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h1, 8'h22);
    @(negedge clk);
    checkOutput("fwd_sel3_b", bus.y, 32'h1);
    bus.fwd_sel = 2'd1;
    applyStimulus(1'b1, 3'd4, 32'h5, 32'h1, 8'h23);
    @(negedge clk);
    checkOutput("fwd_ignored_imm", bus.y, 32'h5);
    bus.fwd_sel = 2'd0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    @(negedge clk);

    // Asynchronous reset while full
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h3030, 8'h30);
    @(negedge clk);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h3131, 8'h31);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    checkOutput("ar_occ_full", 32'(bus.occupancy), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("ar_occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("ar_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("ar_y", bus.y, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'd4, 32'h0000_1234, 32'h0, 8'h32);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 8'h0);
    checkOutput("ar_post_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("ar_post_y", bus.y, 32'h0000_1234);
    checkOutput("ar_post_tag", 32'(bus.tag_out), 32'h32);
    @(negedge clk);
    checkOutput("ar_post_drain", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
